// File: rtl/memory_port_arbiter_if.sv
// Bundle of request, response and byte-wide RAM signals around memory_port_arbiter.
// IO_BUFFER_FULL_STALL_EN adds the io_buffer_full input.
interface memory_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              rdy_in;
    logic              flush_pipline;
    logic              ifetch_req;
    logic [ADDR_W-1:0] ifetch_addr;
    logic              ifetch_done;
    logic [31:0]       ifetch_data;
    logic              data_req;
    logic              data_we;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_done;
    logic [31:0]       data_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
`ifdef IO_BUFFER_FULL_STALL_EN
    logic              io_buffer_full;

    modport slave (
        input  rdy_in, flush_pipline, ifetch_req, ifetch_addr, data_req, data_we,
               data_size, data_addr, data_wdata, mem_din, io_buffer_full,
        output ifetch_done, ifetch_data, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );
    modport master (
        output rdy_in, flush_pipline, ifetch_req, ifetch_addr, data_req, data_we,
               data_size, data_addr, data_wdata, mem_din, io_buffer_full,
        input  ifetch_done, ifetch_data, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );
`else
    modport slave (
        input  rdy_in, flush_pipline, ifetch_req, ifetch_addr, data_req, data_we,
               data_size, data_addr, data_wdata, mem_din,
        output ifetch_done, ifetch_data, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );
    modport master (
        output rdy_in, flush_pipline, ifetch_req, ifetch_addr, data_req, data_we,
               data_size, data_addr, data_wdata, mem_din,
        input  ifetch_done, ifetch_data, data_done, data_rdata, mem_dout, mem_a, mem_wr
    );
`endif
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter serialising icache fetches and load/store requests onto one byte-wide RAM port.
// Optional IO_BUFFER_FULL_STALL_EN defers stores to the IO buffer addresses while io_buffer_full is high.
module memory_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int IFETCH_LEN = 4
) (
    input logic                   clk_in,
    input logic                   rst_n_in,
    memory_port_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [1:0] IF_LAST  = 2'(IFETCH_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] byte_ins(input logic [31:0] word, input logic [1:0] idx,
                                            input logic [7:0] b);
      byte_ins = word;
      case (idx)
         2'd0:    byte_ins[7:0]   = b;
         2'd1:    byte_ins[15:8]  = b;
         2'd2:    byte_ins[23:16] = b;
         2'd3:    byte_ins[31:24] = b;
         default: byte_ins        = word;
      endcase
   endfunction

   function automatic logic [1:0] size_last(input logic [1:0] size);
      case (size)
         2'd0:    size_last = 2'd0;
         2'd1:    size_last = 2'd1;
         default: size_last = 2'd3;
      endcase
   endfunction

   logic [1:0]        state_r;
   logic [1:0]        idx_r;
   logic [1:0]        last_idx_r;
   logic              owner_fetch_r;
   logic              we_r;
   logic              last_fetch_r;
   logic [31:0]       wdata_r;
   logic [31:0]       buf_r;
   logic              pend_vld_r;
   logic [1:0]        pend_idx_r;
   logic [ADDR_W-1:0] mem_a_r;
   logic [7:0]        mem_dout_r;
   logic              mem_wr_r;
   logic              ifetch_done_r;
   logic [31:0]       ifetch_data_r;
   logic              data_done_r;
   logic [31:0]       data_rdata_r;

   logic              arb_free_s;
   logic              io_stall_s;
   logic              fetch_elig_s;
   logic              data_elig_s;
   logic              grant_fetch_s;
   logic              grant_data_s;
   logic              abort_s;
   logic [ADDR_W-1:0] g_addr_s;
   logic              g_we_s;
   logic [1:0]        g_last_s;
   logic [31:0]       buf_nxt_s;

`ifdef IO_BUFFER_FULL_STALL_EN
   assign io_stall_s = bus.io_buffer_full & bus.data_we &
                       ((bus.data_addr == ADDR_W'(32'h0003_0000)) |
                        (bus.data_addr == ADDR_W'(32'h0003_0004)));
`else
   assign io_stall_s = 1'b0;
`endif

   // The done cycle behaves like IDLE so back-to-back grants lose no cycle.
   assign arb_free_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
   assign fetch_elig_s = bus.ifetch_req & ~bus.flush_pipline;
   assign data_elig_s  = bus.data_req & ~io_stall_s;
   assign abort_s      = owner_fetch_r & bus.flush_pipline &
                         ((state_r == ST_XFER) || (state_r == ST_DRAIN));
   assign g_addr_s     = grant_fetch_s ? bus.ifetch_addr : bus.data_addr;
   assign g_we_s       = grant_data_s & bus.data_we;
   assign g_last_s     = grant_fetch_s ? IF_LAST : size_last(bus.data_size);
   assign buf_nxt_s    = pend_vld_r ? byte_ins(buf_r, pend_idx_r, bus.mem_din) : buf_r;

   // Round-robin grant decision between fetch and load/store.
   always_comb begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
      if (arb_free_s && bus.rdy_in) begin
         if (fetch_elig_s && data_elig_s) begin
            if (last_fetch_r) begin
               grant_data_s = 1'b1;
            end else begin
               grant_fetch_s = 1'b1;
            end
         end else if (fetch_elig_s) begin
            grant_fetch_s = 1'b1;
         end else if (data_elig_s) begin
            grant_data_s = 1'b1;
         end else begin
            grant_data_s = 1'b0;
         end
      end else begin
         grant_fetch_s = 1'b0;
      end
   end

   // Transfer FSM, byte issue and completion pulses.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r       <= ST_IDLE;
         idx_r         <= 2'd0;
         last_idx_r    <= 2'd0;
         owner_fetch_r <= 1'b0;
         we_r          <= 1'b0;
         last_fetch_r  <= 1'b0;
         wdata_r       <= 32'h0;
         mem_a_r       <= '0;
         mem_dout_r    <= 8'h00;
         mem_wr_r      <= 1'b0;
         ifetch_done_r <= 1'b0;
         ifetch_data_r <= 32'h0;
         data_done_r   <= 1'b0;
         data_rdata_r  <= 32'h0;
      end else if (bus.rdy_in) begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               ifetch_done_r <= 1'b0;
               data_done_r   <= 1'b0;
               if (grant_fetch_s || grant_data_s) begin
                  state_r       <= ST_XFER;
                  idx_r         <= 2'd0;
                  last_idx_r    <= g_last_s;
                  owner_fetch_r <= grant_fetch_s;
                  last_fetch_r  <= grant_fetch_s;
                  we_r          <= g_we_s;
                  wdata_r       <= bus.data_wdata;
                  mem_a_r       <= g_addr_s;
                  mem_wr_r      <= g_we_s;
                  mem_dout_r    <= g_we_s ? bus.data_wdata[7:0] : 8'h00;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_XFER: begin
               if (abort_s || (idx_r == last_idx_r)) begin
                  mem_a_r    <= '0;
                  mem_wr_r   <= 1'b0;
                  mem_dout_r <= 8'h00;
                  if (abort_s) begin
                     state_r <= ST_IDLE;
                  end else if (we_r) begin
                     state_r     <= ST_DONE;
                     data_done_r <= 1'b1;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else begin
                  idx_r      <= idx_r + 2'd1;
                  mem_a_r    <= mem_a_r + ADDR_ONE;
                  mem_wr_r   <= we_r;
                  mem_dout_r <= we_r ? byte_sel(wdata_r, idx_r + 2'd1) : 8'h00;
               end
            end
            ST_DRAIN: begin
               if (abort_s) begin
                  state_r <= ST_IDLE;
               end else if (owner_fetch_r) begin
                  state_r       <= ST_DONE;
                  ifetch_done_r <= 1'b1;
                  ifetch_data_r <= buf_nxt_s;
               end else begin
                  state_r      <= ST_DONE;
                  data_done_r  <= 1'b1;
                  data_rdata_r <= buf_nxt_s;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Read capture follows the address actually presented last cycle, so a
   // stall that freezes the bus still assembles every byte from its own address.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend_vld_r <= 1'b0;
         pend_idx_r <= 2'd0;
         buf_r      <= 32'h0;
      end else begin
         pend_vld_r <= (state_r == ST_XFER) && !we_r;
         pend_idx_r <= idx_r;
         buf_r      <= (grant_fetch_s || grant_data_s) ? 32'h0 : buf_nxt_s;
      end
   end

   assign bus.mem_a       = mem_a_r;
   assign bus.mem_dout    = mem_dout_r;
   assign bus.mem_wr      = mem_wr_r & bus.rdy_in;
   assign bus.ifetch_done = ifetch_done_r;
   assign bus.ifetch_data = ifetch_data_r;
   assign bus.data_done   = data_done_r;
   assign bus.data_rdata  = data_rdata_r;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed requests push expected bus bytes and done pulses,
// a negedge monitor compares them against what the DUT presents.
module tb_memory_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   memory_port_arbiter_if bus_if ();
   memory_port_arbiter dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_if));

   typedef struct { logic [31:0] addr; logic wr; logic [7:0] dout; int at; } bus_t;
   typedef struct { logic is_fetch; logic chk; logic [31:0] data; int at; } done_t;

   bus_t  bus_q[$];
   done_t done_q[$];
   bus_t  be;
   done_t de;
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   int    c;
   logic [7:0]  ram   [0:65535];
   logic        wrote [0:65535];
   logic [31:0] got_data;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100: init_byte = 8'h13;  32'h101: init_byte = 8'h05;
         32'h200: init_byte = 8'h37;  32'h201: init_byte = 8'h12;
         32'h204: init_byte = 8'h01;  32'h205: init_byte = 8'h02;
         32'h206: init_byte = 8'h03;  32'h207: init_byte = 8'h04;
         32'h400: init_byte = 8'hEF;  32'h401: init_byte = 8'hBE;
         32'h402: init_byte = 8'hAD;  32'h403: init_byte = 8'hDE;
         32'h300: init_byte = 8'h77;  32'h301: init_byte = 8'h66;
         default: init_byte = 8'h00;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Byte RAM with one-cycle read latency
   always @(posedge clk) begin
      if (bus_if.mem_wr) begin
         ram[bus_if.mem_a[15:0]]   <= bus_if.mem_dout;
         wrote[bus_if.mem_a[15:0]] <= 1'b1;
      end
      bus_if.mem_din <= (wrote[bus_if.mem_a[15:0]] === 1'b1) ? ram[bus_if.mem_a[15:0]]
                                                            : init_byte(bus_if.mem_a);
   end

   task automatic at_cycle(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic wr, input logic [7:0] d, input int t);
      bus_t e;
      e.addr = a; e.wr = wr; e.dout = d; e.at = t;
      bus_q.push_back(e);
   endtask

   task automatic exp_done(input logic f, input logic chk, input logic [31:0] d, input int t);
      done_t e;
      e.is_fetch = f; e.chk = chk; e.data = d; e.at = t;
      done_q.push_back(e);
   endtask

   task automatic set_data(input logic req, input logic we, input logic [1:0] size,
                           input logic [31:0] a, input logic [31:0] wd);
      bus_if.data_req = req; bus_if.data_we = we; bus_if.data_size = size;
      bus_if.data_addr = a; bus_if.data_wdata = wd;
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (bus_if.mem_a !== 32'h0 || bus_if.mem_wr !== 1'b0 || bus_if.mem_dout !== 8'h00 ||
          bus_if.ifetch_done !== 1'b0 || bus_if.data_done !== 1'b0) begin
         failures++;
         $display("FAIL %s got a=%h wr=%b d=%h fd=%b dd=%b required all zero", name,
                  bus_if.mem_a, bus_if.mem_wr, bus_if.mem_dout, bus_if.ifetch_done, bus_if.data_done);
      end
   endtask

   // Monitor: bus bytes, stall gating and done pulses
   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus_if.rdy_in) begin
            checks++;
            if (bus_if.mem_wr !== 1'b0) begin
               failures++;
               $display("FAIL mem_wr_stall cycle=%0d got=%b required=0", cyc, bus_if.mem_wr);
            end
         end else if (bus_if.mem_wr || bus_if.mem_a != 32'h0) begin
            checks++;
            if (bus_q.size() == 0) begin
               failures++;
               $display("FAIL bus_unexpected cycle=%0d got a=%h wr=%b d=%h required none",
                        cyc, bus_if.mem_a, bus_if.mem_wr, bus_if.mem_dout);
            end else begin
               be = bus_q.pop_front();
               if (bus_if.mem_a !== be.addr || bus_if.mem_wr !== be.wr ||
                   bus_if.mem_dout !== be.dout || cyc != be.at) begin
                  failures++;
                  $display("FAIL bus_access cycle=%0d got a=%h wr=%b d=%h required a=%h wr=%b d=%h cycle=%0d",
                           cyc, bus_if.mem_a, bus_if.mem_wr, bus_if.mem_dout, be.addr, be.wr, be.dout, be.at);
               end
            end
         end
         if (bus_if.ifetch_done || bus_if.data_done) begin
            checks++;
            got_data = bus_if.ifetch_done ? bus_if.ifetch_data : bus_if.data_rdata;
            if (bus_if.ifetch_done && bus_if.data_done) begin
               failures++;
               $display("FAIL done_both cycle=%0d got both pulses required one", cyc);
            end else if (done_q.size() == 0) begin
               failures++;
               $display("FAIL done_unexpected cycle=%0d got fetch=%b data=%h required none",
                        cyc, bus_if.ifetch_done, got_data);
            end else begin
               de = done_q.pop_front();
               if (bus_if.ifetch_done !== de.is_fetch || cyc != de.at ||
                   (de.chk && got_data !== de.data)) begin
                  failures++;
                  $display("FAIL done_pulse cycle=%0d got fetch=%b data=%h required fetch=%b data=%h cycle=%0d",
                           cyc, bus_if.ifetch_done, got_data, de.is_fetch, de.data, de.at);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus_if.rdy_in = 1'b1; bus_if.flush_pipline = 1'b0;
      bus_if.ifetch_req = 1'b0; bus_if.ifetch_addr = 32'h0;
      set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
`ifdef IO_BUFFER_FULL_STALL_EN
      bus_if.io_buffer_full = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check_idle_outputs("reset_state");

      // Word fetch @0x100
      at_cycle(cyc + 2); c = cyc;
      bus_if.ifetch_req = 1'b1; bus_if.ifetch_addr = 32'h100;
      for (int k = 0; k < 4; k++) exp_bus(32'h100 + k, 1'b0, 8'h00, c + 1 + k);
      exp_done(1'b1, 1'b1, 32'h0000_0513, c + 6);
      at_cycle(c + 6); bus_if.ifetch_req = 1'b0;

      // Flush in IDLE holds off the fetch one cycle
      at_cycle(cyc + 2); c = cyc;
      bus_if.flush_pipline = 1'b1; bus_if.ifetch_req = 1'b1; bus_if.ifetch_addr = 32'h100;
      for (int k = 0; k < 4; k++) exp_bus(32'h100 + k, 1'b0, 8'h00, c + 2 + k);
      exp_done(1'b1, 1'b1, 32'h0000_0513, c + 7);
      at_cycle(c + 1); bus_if.flush_pipline = 1'b0;
      at_cycle(c + 7); bus_if.ifetch_req = 1'b0;

      // Half store @0x2002
      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b1, 2'd1, 32'h2002, 32'hAABB_CCDD);
      exp_bus(32'h2002, 1'b1, 8'hDD, c + 1);
      exp_bus(32'h2003, 1'b1, 8'hCC, c + 2);
      exp_done(1'b0, 1'b0, 32'h0, c + 3);
      at_cycle(c + 3); bus_if.data_req = 1'b0;

      // Half store wrapping past 0xFFFFFFFF
      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_5AA5);
      exp_bus(32'hFFFF_FFFF, 1'b1, 8'hA5, c + 1);
      exp_bus(32'h0000_0000, 1'b1, 8'h5A, c + 2);
      exp_done(1'b0, 1'b0, 32'h0, c + 3);
      at_cycle(c + 3); bus_if.data_req = 1'b0;

      // Word store with one stalled cycle, then read back
      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b1, 2'd2, 32'h500, 32'h0403_0201);
      exp_bus(32'h500, 1'b1, 8'h01, c + 1);
      exp_bus(32'h501, 1'b1, 8'h02, c + 3);
      exp_bus(32'h502, 1'b1, 8'h03, c + 4);
      exp_bus(32'h503, 1'b1, 8'h04, c + 5);
      exp_done(1'b0, 1'b0, 32'h0, c + 6);
      at_cycle(c + 2); bus_if.rdy_in = 1'b0;
      at_cycle(c + 3); bus_if.rdy_in = 1'b1;
      at_cycle(c + 6); bus_if.data_req = 1'b0;

      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b0, 2'd3, 32'h500, 32'h0);
      for (int k = 0; k < 4; k++) exp_bus(32'h500 + k, 1'b0, 8'h00, c + 1 + k);
      exp_done(1'b0, 1'b1, 32'h0403_0201, c + 6);
      at_cycle(c + 6); bus_if.data_req = 1'b0;

      // Word load with rdy_in low for three cycles
      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
      exp_bus(32'h400, 1'b0, 8'h00, c + 1);
      exp_bus(32'h401, 1'b0, 8'h00, c + 2);
      exp_bus(32'h402, 1'b0, 8'h00, c + 6);
      exp_bus(32'h403, 1'b0, 8'h00, c + 7);
      exp_done(1'b0, 1'b1, 32'hDEAD_BEEF, c + 9);
      at_cycle(c + 3); bus_if.rdy_in = 1'b0;
      at_cycle(c + 6); bus_if.rdy_in = 1'b1;
      at_cycle(c + 9); bus_if.data_req = 1'b0;

      // Flush in cycle 2 of a fetch, pending byte load follows
      at_cycle(cyc + 2); c = cyc;
      bus_if.ifetch_req = 1'b1; bus_if.ifetch_addr = 32'h300;
      exp_bus(32'h300, 1'b0, 8'h00, c + 1);
      exp_bus(32'h301, 1'b0, 8'h00, c + 2);
      exp_bus(32'h401, 1'b0, 8'h00, c + 4);
      exp_done(1'b0, 1'b1, 32'h0000_00BE, c + 6);
      at_cycle(c + 1); set_data(1'b1, 1'b0, 2'd0, 32'h401, 32'h0);
      at_cycle(c + 2); bus_if.flush_pipline = 1'b1; bus_if.ifetch_req = 1'b0;
      at_cycle(c + 3); bus_if.flush_pipline = 1'b0;
      at_cycle(c + 6); bus_if.data_req = 1'b0;

      // Reset pulse in the middle of a word store
      at_cycle(cyc + 2); c = cyc;
      set_data(1'b1, 1'b1, 2'd2, 32'h3000, 32'h1122_3344);
      exp_bus(32'h3000, 1'b1, 8'h44, c + 1);
      at_cycle(c + 2); rst_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      bus_if.data_req = 1'b0;
      at_cycle(c + 4); rst_n = 1'b1;

      // Both requesting after reset: fetch, then data, then the next fetch
      at_cycle(cyc + 2); c = cyc;
      bus_if.ifetch_req = 1'b1; bus_if.ifetch_addr = 32'h200;
      set_data(1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
      for (int k = 0; k < 4; k++) exp_bus(32'h200 + k, 1'b0, 8'h00, c + 1 + k);
      for (int k = 0; k < 4; k++) exp_bus(32'h400 + k, 1'b0, 8'h00, c + 7 + k);
      for (int k = 0; k < 4; k++) exp_bus(32'h204 + k, 1'b0, 8'h00, c + 13 + k);
      exp_done(1'b1, 1'b1, 32'h0000_1237, c + 6);
      exp_done(1'b0, 1'b1, 32'hDEAD_BEEF, c + 12);
      exp_done(1'b1, 1'b1, 32'h0403_0201, c + 18);
      at_cycle(c + 6); bus_if.ifetch_addr = 32'h204;
      at_cycle(c + 12); bus_if.data_req = 1'b0;
      at_cycle(c + 18); bus_if.ifetch_req = 1'b0;

      at_cycle(cyc + 6);
      checks++;
      if (bus_q.size() != 0) begin
         failures++;
         $display("FAIL bus_leftover got=%0d pending required=0", bus_q.size());
      end
      checks++;
      if (done_q.size() != 0) begin
         failures++;
         $display("FAIL done_leftover got=%0d pending required=0", done_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
